// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_REFETCH = 2'd3
    } seq_state_t;

    localparam int REG_IDX_W   = 5;
    localparam int DRAIN_CNT_W = 3;

    function automatic logic src_matches(input logic use_rs,
                                         input logic [REG_IDX_W-1:0] rs,
                                         input logic [REG_IDX_W-1:0] rd);
        return use_rs && (rs == rd);
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Decoder fields, memory handshake and stall/flush controls between datapath and sequencer.
interface pipe_stall_ctrl_if;
    import pipe_stall_ctrl_pkg::*;

    logic                 id_use_rs1;
    logic                 id_use_rs2;
    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic                 ex_is_load;
    logic                 ex_we_reg;
    logic [REG_IDX_W-1:0] ex_rd;
    logic                 ex_fence;
    logic                 ex_redirect;
    logic                 mem_req;
    logic                 mem_ready;
    logic                 tlb_flush_ack;
    logic                 stall_if;
    logic                 stall_id;
    logic                 stall_ex;
    logic                 stall_mem;
    logic                 flush_id;
    logic                 flush_ex;
    logic                 tlb_flush_req;
    logic                 fence_refetch;
    logic                 flush_err;

    modport master (
        output id_use_rs1, id_use_rs2, id_rs1, id_rs2,
        output ex_is_load, ex_we_reg, ex_rd, ex_fence, ex_redirect,
        output mem_req, mem_ready, tlb_flush_ack,
        input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
        input  tlb_flush_req, fence_refetch, flush_err
    );

    modport slave (
        input  id_use_rs1, id_use_rs2, id_rs1, id_rs2,
        input  ex_is_load, ex_we_reg, ex_rd, ex_fence, ex_redirect,
        input  mem_req, mem_ready, tlb_flush_ack,
        output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
        output tlb_flush_req, fence_refetch, flush_err
    );

endinterface

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Load-use hazard detection between the ID instruction and a load in EX.
module hazard_detect
    import pipe_stall_ctrl_pkg::*;
(
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 ex_is_load,
    input  logic                 ex_we_reg,
    input  logic [REG_IDX_W-1:0] ex_rd,
    output logic                 load_use
);

    // x0 is never a real producer, so a load targeting it creates no hazard.
    assign load_use = ex_is_load && ex_we_reg && (ex_rd != '0) &&
                      (src_matches(id_use_rs1, id_rs1, ex_rd) ||
                       src_matches(id_use_rs2, id_rs2, ex_rd));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Per-stage stall/flush priority mux plus the sfence.vma drain / TLB flush / refetch sequencer.
// state   | meaning
// IDLE    | normal issue; honours fence, redirect and load-use
// DRAIN   | older insts retiring from MEM/WB before the TLB flush
// FLUSH   | tlb_flush_req held, waiting for ack or timeout
// REFETCH | fence_refetch pulse issued, then back to IDLE
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int ACK_TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              rstn,
    pipe_stall_ctrl_if.slave  bus
);

    localparam int ACK_CNT_W = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [ACK_CNT_W-1:0]   ACK_LAST   = ACK_CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
    localparam bit   TIMEOUT_EN = (ACK_TIMEOUT != 0);

    seq_state_t             state, state_nxt;
    logic [DRAIN_CNT_W-1:0] drain_cnt, drain_nxt;
    logic [ACK_CNT_W-1:0]   ack_cnt, ack_nxt;
    logic                   req_q, req_nxt;
    logic                   refetch_q, refetch_nxt;
    logic                   err_q, err_nxt;
    logic                   mem_stall, load_use;
    logic                   s_if, s_id, s_ex, s_mem, f_id, f_ex;

    hazard_detect u_hazard_detect (
        .id_use_rs1 (bus.id_use_rs1),
        .id_use_rs2 (bus.id_use_rs2),
        .id_rs1     (bus.id_rs1),
        .id_rs2     (bus.id_rs2),
        .ex_is_load (bus.ex_is_load),
        .ex_we_reg  (bus.ex_we_reg),
        .ex_rd      (bus.ex_rd),
        .load_use   (load_use)
    );

    assign mem_stall = bus.mem_req && !bus.mem_ready;

    always_comb begin
        s_if        = 1'b0;
        s_id        = 1'b0;
        s_ex        = 1'b0;
        s_mem       = 1'b0;
        f_id        = 1'b0;
        f_ex        = 1'b0;
        state_nxt   = state;
        drain_nxt   = drain_cnt;
        ack_nxt     = ack_cnt;
        req_nxt     = req_q;
        err_nxt     = err_q;
        refetch_nxt = 1'b0;
        if (mem_stall) begin
            // Whole pipe freezes, sequencer included; no bubbles while held.
            s_if  = 1'b1;
            s_id  = 1'b1;
            s_ex  = 1'b1;
            s_mem = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.ex_fence) begin
                        s_if      = 1'b1;
                        f_id      = 1'b1;
                        f_ex      = 1'b1;
                        state_nxt = ST_DRAIN;
                        drain_nxt = DRAIN_LOAD;
                    end else if (bus.ex_redirect) begin
                        f_id = 1'b1;
                        f_ex = 1'b1;
                    end else if (load_use) begin
                        s_if = 1'b1;
                        f_ex = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    drain_nxt = (drain_cnt == '0) ? '0 : drain_cnt - 1'b1;
                    // Leave on the cycle the count would reach zero.
                    if (drain_cnt <= DRAIN_CNT_W'(1)) begin
                        state_nxt = ST_FLUSH;
                        req_nxt   = 1'b1;
                        ack_nxt   = '0;
                    end
                end
                ST_FLUSH: begin
                    ack_nxt = ack_cnt + ACK_CNT_W'(1);
                    if (bus.tlb_flush_ack) begin
                        state_nxt = ST_REFETCH;
                        req_nxt   = 1'b0;
                    end else if (TIMEOUT_EN && (ack_cnt == ACK_LAST)) begin
                        state_nxt = ST_REFETCH;
                        req_nxt   = 1'b0;
                        err_nxt   = 1'b1;
                    end
                end
                ST_REFETCH: begin
                    refetch_nxt = 1'b1;
                    state_nxt   = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
            if (state != ST_IDLE) begin
                s_if = 1'b1;
                f_id = 1'b1;
                f_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            ack_cnt   <= '0;
            req_q     <= 1'b0;
            refetch_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            ack_cnt   <= ack_nxt;
            req_q     <= req_nxt;
            refetch_q <= refetch_nxt;
            err_q     <= err_nxt;
        end
    end

    assign bus.stall_if      = s_if;
    assign bus.stall_id      = s_id;
    assign bus.stall_ex      = s_ex;
    assign bus.stall_mem     = s_mem;
    assign bus.flush_id      = f_id;
    assign bus.flush_ex      = f_ex;
    assign bus.tlb_flush_req = req_q;
    assign bus.fence_refetch = refetch_q;
    assign bus.flush_err     = err_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed hazards/fence cases plus random traffic.
module tb_pipe_stall_ctrl;

    localparam int DRAIN = 2;
    localparam int TMO   = 4;

    typedef struct packed {
        logic       use_rs1;
        logic       use_rs2;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       is_load;
        logic       we_reg;
        logic [4:0] rd;
        logic       fence;
        logic       redirect;
        logic       mem_req;
        logic       mem_ready;
        logic       ack;
    } in_t;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fail;
    int   cyc_no;

    // Reference model: sequence position counted in un-stalled cycles since the fence.
    bit   m_busy;
    int   m_k;
    int   m_end;
    bit   m_req;
    bit   m_refetch;
    bit   m_err;

    logic [8:0] exp_q[$];

    pipe_stall_ctrl_if bus ();

    pipe_stall_ctrl #(.DRAIN_CYCLES(DRAIN), .ACK_TIMEOUT(TMO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] dut_outs();
        return {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem, bus.flush_id,
                bus.flush_ex, bus.tlb_flush_req, bus.fence_refetch, bus.flush_err};
    endfunction

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b (if id ex mem fid fex req rf err)",
                     name, cyc_no, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) chk("outputs", dut_outs(), exp_q.pop_front());
    end

    function automatic in_t idle_in();
        in_t v;
        v = '0;
        v.mem_ready = 1'b1;
        return v;
    endfunction

    task automatic apply(input in_t v);
        bus.id_use_rs1    = v.use_rs1;
        bus.id_use_rs2    = v.use_rs2;
        bus.id_rs1        = v.rs1;
        bus.id_rs2        = v.rs2;
        bus.ex_is_load    = v.is_load;
        bus.ex_we_reg     = v.we_reg;
        bus.ex_rd         = v.rd;
        bus.ex_fence      = v.fence;
        bus.ex_redirect   = v.redirect;
        bus.mem_req       = v.mem_req;
        bus.mem_ready     = v.mem_ready;
        bus.tlb_flush_ack = v.ack;
    endtask

    task automatic model_reset();
        m_busy = 0; m_k = 0; m_end = -1; m_req = 0; m_refetch = 0; m_err = 0;
    endtask

    // Advance the model across one clock edge using the inputs held during the cycle.
    task automatic model_edge();
        bit ms;
        ms = bus.mem_req && !bus.mem_ready;
        m_refetch = 0;
        if (!ms) begin
            if (!m_busy) begin
                if (bus.ex_fence) begin
                    m_busy = 1; m_k = 1; m_end = -1;
                end
            end else begin
                if (m_end < 0 && m_k >= DRAIN) begin
                    if (bus.tlb_flush_ack) m_end = m_k;
                    else if (TMO != 0 && m_k - DRAIN == TMO - 1) begin
                        m_end = m_k;
                        m_err = 1;
                    end
                end else if (m_end >= 0 && m_k == m_end + 1) begin
                    m_busy = 0;
                    m_refetch = 1;
                end
                m_k++;
            end
        end
        m_req = m_busy && m_end < 0 && m_k >= DRAIN;
    endtask

    function automatic logic [8:0] model_outs(input in_t v);
        bit ms, lu;
        bit s_if, s_id, s_ex, s_mem, f_id, f_ex;
        ms = v.mem_req && !v.mem_ready;
        lu = v.is_load && v.we_reg && v.rd != 0 &&
             ((v.use_rs1 && v.rs1 == v.rd) || (v.use_rs2 && v.rs2 == v.rd));
        {s_if, s_id, s_ex, s_mem, f_id, f_ex} = '0;
        if (ms) {s_if, s_id, s_ex, s_mem} = 4'b1111;
        else if (m_busy || v.fence) {s_if, f_id, f_ex} = 3'b111;
        else if (v.redirect) {f_id, f_ex} = 2'b11;
        else if (lu) {s_if, f_ex} = 2'b11;
        return {s_if, s_id, s_ex, s_mem, f_id, f_ex, m_req, m_refetch, m_err};
    endfunction

    task automatic cyc(input in_t v);
        @(posedge clk);
        #1;
        cyc_no++;
        model_edge();
        apply(v);
        exp_q.push_back(model_outs(v));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(idle_in());
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock arrives.
    task automatic reset_now();
        @(posedge clk);
        #2;
        rstn = 1'b0;
        apply(idle_in());
        #1;
        model_reset();
        chk("async_reset", dut_outs(), 9'b0);
        @(posedge clk);
        #2;
        chk("reset_held", dut_outs(), 9'b0);
        rstn = 1'b1;
    endtask

    initial begin : watchdog
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : stim
        in_t v;
        n_checks = 0;
        n_fail   = 0;
        cyc_no   = 0;
        model_reset();
        rstn = 1'b0;
        apply(idle_in());
        #12;
        chk("reset_state", dut_outs(), 9'b0);
        #10 rstn = 1'b1;

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID -> one bubble, then the add proceeds.
        v = idle_in();
        v.is_load = 1; v.we_reg = 1; v.rd = 5;
        v.use_rs1 = 1; v.rs1 = 5; v.use_rs2 = 1; v.rs2 = 1;
        cyc(v);
        v.is_load = 0; v.we_reg = 0; v.rd = 0;
        cyc(v);
        // No hazard for rd=x0 or when rs1 is not read.
        v = idle_in();
        v.is_load = 1; v.we_reg = 1; v.rd = 0; v.use_rs1 = 1; v.rs1 = 0;
        cyc(v);
        v.rd = 5; v.rs1 = 5; v.use_rs1 = 0;
        cyc(v);

        // Memory wait during a load-use hazard: full freeze, bubble on the first ready cycle.
        v = idle_in();
        v.is_load = 1; v.we_reg = 1; v.rd = 7; v.use_rs2 = 1; v.rs2 = 7;
        v.mem_req = 1; v.mem_ready = 0;
        for (int i = 0; i < 3; i++) cyc(v);
        v.mem_ready = 1;
        cyc(v);
        idle_cycles(1);

        // Taken branch in IDLE.
        v = idle_in();
        v.redirect = 1;
        cyc(v);
        idle_cycles(1);

        // sfence with the ack arriving three cycles after the request (last legal ack cycle).
        v = idle_in();
        v.fence = 1;
        cyc(v);
        for (int i = 1; i <= 8; i++) begin
            v = idle_in();
            v.ack = (i == 5);
            cyc(v);
        end

        // Random traffic; fences are rare so most cycles exercise the priority mux.
        for (int i = 0; i < 600; i++) begin
            v.use_rs1   = 1'($urandom_range(0, 1));
            v.use_rs2   = 1'($urandom_range(0, 1));
            v.rs1       = 5'($urandom_range(0, 3));
            v.rs2       = 5'($urandom_range(0, 3));
            v.is_load   = 1'($urandom_range(0, 1));
            v.we_reg    = ($urandom_range(0, 3) != 0);
            v.rd        = 5'($urandom_range(0, 3));
            v.fence     = ($urandom_range(0, 19) == 0);
            v.redirect  = ($urandom_range(0, 6) == 0);
            v.mem_req   = ($urandom_range(0, 9) < 4);
            v.mem_ready = ($urandom_range(0, 9) < 6);
            v.ack       = ($urandom_range(0, 9) < 3);
            cyc(v);
        end

        // Bring the sequencer back to IDLE, start a fence, reset while in FLUSH.
        for (int i = 0; i < 40 && m_busy; i++) idle_cycles(1);
        idle_cycles(2);
        v = idle_in();
        v.fence = 1;
        cyc(v);
        idle_cycles(2);
        reset_now();
        v = idle_in();
        v.is_load = 1; v.we_reg = 1; v.rd = 3; v.use_rs1 = 1; v.rs1 = 3;
        cyc(v);
        idle_cycles(2);

        // Ack timeout: error after four FLUSH cycles, refetch still issued, error sticky.
        v = idle_in();
        v.fence = 1;
        cyc(v);
        idle_cycles(12);
        v = idle_in();
        v.redirect = 1;
        cyc(v);
        idle_cycles(2);
        reset_now();
        idle_cycles(3);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expected entries never compared", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
